// File: rtl/font_overlay_mixer_pkg.sv
// Shared types and constants for the banner font path.
// The address generator uses the same banner geometry values.
package font_overlay_mixer_pkg;

  localparam int RGB444_W = 12;
  localparam int CNT_W    = 10;

  // Banner geometry shared with the font address generator
  localparam int BANNER_X0     = 160;
  localparam int BANNER_Y0     = 390;
  localparam int BANNER_WIDTH  = 320;
  localparam int BANNER_HEIGHT = 50;

  // First non-visible line; the frame tick fires at column 0 of this line
  localparam int FRAME_TICK_LINE = 480;

  typedef logic [RGB444_W-1:0] rgb444_t;
  typedef logic [CNT_W-1:0]    coord_t;

  typedef enum logic [1:0] {
    ST_HIDE      = 2'b00,
    ST_SHOW      = 2'b01,
    ST_BLINK_ON  = 2'b10,
    ST_BLINK_OFF = 2'b11
  } text_state_t;

  typedef enum logic [1:0] {
    MODE_HIDE     = 2'b00,
    MODE_SHOW     = 2'b01,
    MODE_BLINK    = 2'b10,
    MODE_HIDE_ALT = 2'b11
  } text_mode_t;

  function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/font_overlay_mixer_if.sv
// Pixel-stream bundle between the VGA timing/BRAM side and the overlay mixer.
// master drives coordinates and BRAM data; slave returns the mixed pixel.
interface font_overlay_mixer_if;
  import font_overlay_mixer_pkg::*;

  coord_t     h_cnt;
  coord_t     v_cnt;
  logic       valid;
  logic [1:0] text_mode;
  rgb444_t    font_data;
  rgb444_t    bg_pixel;
  rgb444_t    pixel_out;
  logic       blink_vis;

  modport master (
    output h_cnt, v_cnt, valid, text_mode, font_data, bg_pixel,
    input  pixel_out, blink_vis
  );

  modport slave (
    input  h_cnt, v_cnt, valid, text_mode, font_data, bg_pixel,
    output pixel_out, blink_vis
  );

endinterface

// File: rtl/font_overlay_mixer_delay_pipe.sv
// Registered shift line of DEPTH stages with synchronous clear.
// Latency: DEPTH cycles. Backpressure: none, shifts every cycle.
module font_overlay_mixer_delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/font_overlay_mixer.sv
// Keys font texels over the background inside the banner, with a frame-synchronous show/hide/blink FSM.
// Latency: BRAM_LAT+1 cycles from h_cnt/v_cnt to pixel_out. Backpressure: none, streams every pixel clock.
module font_overlay_mixer
  import font_overlay_mixer_pkg::*;
#(
  parameter int      BRAM_LAT     = 1,
  parameter int      X0           = BANNER_X0,
  parameter int      Y0           = BANNER_Y0,
  parameter int      BANNER_W     = BANNER_WIDTH,
  parameter int      BANNER_H     = BANNER_HEIGHT,
  parameter rgb444_t KEY_COLOR    = 12'h000,
  parameter int      BLINK_FRAMES = 30,
  parameter int      V_ACTIVE     = FRAME_TICK_LINE
) (
  input  logic                 clk,
  input  logic                 rst,
  font_overlay_mixer_if.slave  bus
);

  localparam coord_t X_LO      = CNT_W'(X0);
  localparam coord_t X_HI      = CNT_W'(X0 + BANNER_W - 1);
  localparam coord_t Y_LO      = CNT_W'(Y0);
  localparam coord_t Y_HI      = CNT_W'(Y0 + BANNER_H - 1);
  localparam coord_t TICK_LINE = CNT_W'(V_ACTIVE);

  // A single-frame blink still needs a one-bit counter to hold zero
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic            in_banner;
  logic            frame_tick;
  logic            in_d;
  logic            valid_d;

  text_state_t     state, state_next;
  logic [FC_W-1:0] frame_cnt, frame_cnt_next;
  logic            vis_next;
  logic            blink_vis_q;
  rgb444_t         pixel_q;

  assign in_banner  = bus.valid
                    && in_window(bus.h_cnt, X_LO, X_HI)
                    && in_window(bus.v_cnt, Y_LO, Y_HI);
  assign frame_tick = (bus.h_cnt == '0) && (bus.v_cnt == TICK_LINE);

  // Region flag and display enable ride alongside the BRAM read
  font_overlay_mixer_delay_pipe #(
    .WIDTH (2),
    .DEPTH (BRAM_LAT)
  ) u_delay_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  ({in_banner, bus.valid}),
    .dout ({in_d, valid_d})
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HIDE;
      frame_cnt <= '0;
    end else begin
      state     <= state_next;
      frame_cnt <= frame_cnt_next;
    end
  end

  // text_mode is only looked at on the frame tick so the text never tears mid-frame
  always_comb begin
    state_next     = state;
    frame_cnt_next = frame_cnt;
    if (frame_tick) begin
      case (bus.text_mode)
        MODE_SHOW: begin
          state_next     = ST_SHOW;
          frame_cnt_next = '0;
        end
        MODE_BLINK: begin
          if ((state == ST_BLINK_ON) || (state == ST_BLINK_OFF)) begin
            if (frame_cnt == FC_LAST) begin
              state_next     = (state == ST_BLINK_ON) ? ST_BLINK_OFF : ST_BLINK_ON;
              frame_cnt_next = '0;
            end else begin
              frame_cnt_next = frame_cnt + FC_W'(1);
            end
          end else begin
            state_next     = ST_BLINK_ON;
            frame_cnt_next = '0;
          end
        end
        default: begin
          state_next     = ST_HIDE;
          frame_cnt_next = '0;
        end
      endcase
    end
    vis_next = (state_next == ST_SHOW) || (state_next == ST_BLINK_ON);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_vis_q <= 1'b0;
      pixel_q     <= '0;
    end else begin
      blink_vis_q <= vis_next;
      if (!valid_d) begin
        pixel_q <= '0;
      end else if (in_d && blink_vis_q && (bus.font_data != KEY_COLOR)) begin
        pixel_q <= bus.font_data;
      end else begin
        pixel_q <= bus.bg_pixel;
      end
    end
  end

  assign bus.pixel_out = pixel_q;
  assign bus.blink_vis = blink_vis_q;

endmodule

// File: tb/tb_font_overlay_mixer.sv
// Scoreboarded bench for font_overlay_mixer with BRAM_LAT=1 and BLINK_FRAMES=3.
module tb_font_overlay_mixer;

  localparam logic [11:0] FONT = 12'hF00;
  localparam logic [11:0] BG   = 12'h00F;
  localparam logic [9:0]  BH   = 10'd300;
  localparam logic [9:0]  BV   = 10'd400;

  typedef struct {
    logic [11:0] pix;
    int unsigned due;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  font_overlay_mixer_if bus();

  font_overlay_mixer #(
    .BRAM_LAT     (1),
    .X0           (160),
    .Y0           (390),
    .BANNER_W     (320),
    .BANNER_H     (50),
    .KEY_COLOR    (12'h000),
    .BLINK_FRAMES (3),
    .V_ACTIVE     (480)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q[$];
  logic [11:0] nxt_font = 12'h000;
  logic [11:0] nxt_bg = 12'h000;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel scoreboard: each expectation is due two edges after its coordinate
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (bus.pixel_out !== e.pix) begin
        n_fail++;
        $display("FAIL %s: pixel_out=%h expected %h", e.tag, bus.pixel_out, e.pix);
      end
    end
  end

  // One pixel clock: new coordinate plus BRAM data for the previous coordinate
  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic vld,
                      input logic [11:0] font, input logic [11:0] bg,
                      input logic chk, input logic [11:0] exp, input string tag);
    exp_t e;
    @(negedge clk);
    bus.h_cnt     = h;
    bus.v_cnt     = v;
    bus.valid     = vld;
    bus.font_data = nxt_font;
    bus.bg_pixel  = nxt_bg;
    nxt_font = font;
    nxt_bg   = bg;
    if (chk) begin
      e.pix = exp;
      e.due = cyc + 2;
      e.tag = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    step(10'd5, 10'd5, 1'b0, 12'h000, 12'h000, 1'b0, 12'h000, "idle");
  endtask

  task automatic tick(input logic [1:0] mode);
    bus.text_mode = mode;
    step(10'd0, 10'd480, 1'b0, 12'h000, 12'h000, 1'b0, 12'h000, "tick");
  endtask

  task automatic test_reset();
    bus.text_mode = 2'b01;
    rst = 1'b1;
    repeat (3) idle();
    n_checks++;
    if (bus.pixel_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_pixel: pixel_out=%h expected 000", bus.pixel_out);
    end
    n_checks++;
    if (bus.blink_vis !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vis: blink_vis=%b expected 0", bus.blink_vis);
    end
    rst = 1'b0;
    repeat (2) idle();
    n_checks++;
    if (bus.blink_vis !== 1'b0) begin
      n_fail++;
      $display("FAIL no_tick_vis: blink_vis=%b expected 0", bus.blink_vis);
    end
  endtask

  task automatic test_show_from_reset();
    tick(2'b01);
    n_checks++;
    if (bus.blink_vis !== 1'b0) begin
      n_fail++;
      $display("FAIL show_before: blink_vis=%b expected 0", bus.blink_vis);
    end
    idle();
    n_checks++;
    if (bus.blink_vis !== 1'b1) begin
      n_fail++;
      $display("FAIL show_after: blink_vis=%b expected 1", bus.blink_vis);
    end
  endtask

  task automatic test_edges();
    logic [9:0]  hs [8] = '{10'd159, 10'd160, 10'd479, 10'd480, 10'd200, 10'd200, 10'd200, 10'd200};
    logic [9:0]  vs [8] = '{10'd400, 10'd400, 10'd400, 10'd400, 10'd389, 10'd390, 10'd439, 10'd440};
    logic [11:0] ex [8] = '{BG, FONT, FONT, BG, BG, FONT, FONT, BG};
    for (int i = 0; i < 8; i++) begin
      step(hs[i], vs[i], 1'b1, FONT, BG, 1'b1, ex[i], $sformatf("edge_h%0d_v%0d", hs[i], vs[i]));
    end
    repeat (2) idle();
  endtask

  task automatic test_transparency_blanking();
    step(BH, BV, 1'b1, 12'h000, 12'h0F0, 1'b1, 12'h0F0, "transparent");
    step(BH, BV, 1'b0, FONT, 12'hFFF, 1'b1, 12'h000, "blank_in_banner");
    step(10'd10, 10'd10, 1'b0, FONT, 12'hFFF, 1'b1, 12'h000, "blank_outside");
    step(BH, BV, 1'b1, 12'h0AB, BG, 1'b1, 12'h0AB, "font_other");
    repeat (2) idle();
  endtask

  task automatic test_reset_midline();
    repeat (3) step(BH, BV, 1'b1, FONT, BG, 1'b0, 12'h000, "pre_reset");
    n_checks++;
    if (bus.pixel_out !== FONT) begin
      n_fail++;
      $display("FAIL pre_reset_pixel: pixel_out=%h expected %h", bus.pixel_out, FONT);
    end
    rst = 1'b1;
    exp_q.delete();
    idle();
    n_checks++;
    if (bus.pixel_out !== 12'h000 || bus.blink_vis !== 1'b0) begin
      n_fail++;
      $display("FAIL midline_reset: pixel_out=%h blink_vis=%b expected 000/0", bus.pixel_out, bus.blink_vis);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle();
      n_checks++;
      if (bus.pixel_out !== 12'h000) begin
        n_fail++;
        $display("FAIL post_reset_hold%0d: pixel_out=%h expected 000", i, bus.pixel_out);
      end
    end
    step(BH, BV, 1'b1, FONT, 12'h0AA, 1'b1, 12'h0AA, "post_reset_hidden");
    repeat (2) idle();
  endtask

  task automatic test_blink();
    logic exp_vis [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic prev_vis;
    prev_vis = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(2'b10);
      n_checks++;
      if (bus.blink_vis !== prev_vis) begin
        n_fail++;
        $display("FAIL blink_hold%0d: blink_vis=%b expected %b", i, bus.blink_vis, prev_vis);
      end
      step(BH, BV, 1'b1, FONT, BG, 1'b1, exp_vis[i] ? FONT : BG, $sformatf("blink_pix%0d", i));
      n_checks++;
      if (bus.blink_vis !== exp_vis[i]) begin
        n_fail++;
        $display("FAIL blink_tick%0d: blink_vis=%b expected %b", i, bus.blink_vis, exp_vis[i]);
      end
      prev_vis = exp_vis[i];
      repeat (2) idle();
    end
  endtask

  task automatic test_deferred_mode();
    tick(2'b01);
    idle();
    step(BH, 10'd200, 1'b1, FONT, BG, 1'b1, BG, "line200");
    bus.text_mode = 2'b00;
    step(BH, BV, 1'b1, FONT, BG, 1'b1, FONT, "deferred_still_shown");
    step(10'd0, 10'd479, 1'b1, FONT, BG, 1'b1, BG, "line479_col0");
    step(10'd1, 10'd480, 1'b0, FONT, BG, 1'b0, 12'h000, "near_tick");
    step(BH, 10'd439, 1'b1, FONT, BG, 1'b1, FONT, "deferred_bottom");
    repeat (2) idle();
    n_checks++;
    if (bus.blink_vis !== 1'b1) begin
      n_fail++;
      $display("FAIL deferred_vis: blink_vis=%b expected 1", bus.blink_vis);
    end
    tick(2'b00);
    idle();
    n_checks++;
    if (bus.blink_vis !== 1'b0) begin
      n_fail++;
      $display("FAIL hide_after_tick: blink_vis=%b expected 0", bus.blink_vis);
    end
    step(BH, BV, 1'b1, FONT, BG, 1'b1, BG, "hidden_banner");
    repeat (2) idle();
    tick(2'b01);
    idle();
    tick(2'b11);
    idle();
    n_checks++;
    if (bus.blink_vis !== 1'b0) begin
      n_fail++;
      $display("FAIL mode11_hide: blink_vis=%b expected 0", bus.blink_vis);
    end
  endtask

  initial begin
    bus.h_cnt     = 10'd5;
    bus.v_cnt     = 10'd5;
    bus.valid     = 1'b0;
    bus.text_mode = 2'b00;
    bus.font_data = 12'h000;
    bus.bg_pixel  = 12'h000;
    test_reset();
    test_show_from_reset();
    test_edges();
    test_transparency_blanking();
    test_reset_midline();
    tick(2'b01);
    idle();
    test_blink();
    test_deferred_mode();
    repeat (3) idle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pixels never checked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
